// File: rtl/function_calling_pkg.sv
// rtl/function_calling_pkg.sv - shared mode encodings and popcount helper for function_calling
package function_calling_pkg;

  localparam int MODE_SOP    = 0;
  localparam int MODE_PARITY = 1;
  localparam int MODE_MAJ    = 2;
  localparam int MODE_THRESH = 3;

  // Number of set bits in a 5-bit operand; the result never exceeds 5, so 3 bits suffice.
  function automatic logic [2:0] popcount5(input logic [4:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]} + {2'b00, v[4]};
  endfunction

endpackage

// File: rtl/function_calling.sv
// rtl/function_calling.sv - registered 5-input boolean evaluator; FUNC_COUNT_EN adds registered ones_cnt output
module function_calling
  import function_calling_pkg::*;
#(
  parameter int MODE   = 0,
  parameter int THRESH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  output logic       f
`ifdef FUNC_COUNT_EN
  ,
  output logic [2:0] ones_cnt
`endif
);

  // Parameter legality is checked once at elaboration; bad values stop the build.
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("function_calling: MODE %0d out of range 0..3", MODE);
  end
  if (THRESH < 0 || THRESH > 5) begin : g_bad_thresh
    $error("function_calling: THRESH %0d out of range 0..5", THRESH);
  end

  localparam logic [2:0] THRESH_L = 3'(THRESH);
  localparam logic [2:0] MAJ_L    = 3'd3;

  function automatic logic sop(input logic [4:0] v);
    return (v[4] & v[3]) | (v[2] & v[1]) | v[0];
  endfunction

  function automatic logic parity(input logic [4:0] v);
    return ^v;
  endfunction

  function automatic logic at_least(input logic [4:0] v, input logic [2:0] k);
    return popcount5(v) >= k;
  endfunction

  // MODE is a constant, so only the selected branch survives synthesis.
  function automatic logic evaluate(input logic [4:0] v);
    logic r;
    case (MODE)
      MODE_SOP:    r = sop(v);
      MODE_PARITY: r = parity(v);
      MODE_MAJ:    r = at_least(v, MAJ_L);
      default:     r = at_least(v, THRESH_L);
    endcase
    return r;
  endfunction

  logic [4:0] opnd;
  logic       f_d;
  logic       f_q;

  assign opnd = {a, b, c, d, e};

  // Next-state value of f taken straight from the current operands.
  always_comb begin
    f_d = evaluate(opnd);
  end

`ifdef FUNC_COUNT_EN
  logic [2:0] cnt_d;
  logic [2:0] cnt_q;

  // Popcount captured alongside f so both share the same one-cycle latency.
  always_comb begin
    cnt_d = popcount5(opnd);
  end

  // Single clocked process: reset clears both registers, otherwise capture every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= 1'b0;
      cnt_q <= 3'd0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign ones_cnt = cnt_q;
`else
  // Single clocked process: reset clears f, otherwise capture every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= 1'b0;
    end else begin
      f_q <= f_d;
    end
  end
`endif

  assign f = f_q;

endmodule

// File: tb/tb_function_calling.sv
// tb/tb_function_calling.sv - scoreboard bench for function_calling across all modes (FUNC_COUNT_EN aware)
module tb_function_calling;

  localparam int NINST = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, e = 1'b0;
  logic [NINST-1:0] f_out;
`ifdef FUNC_COUNT_EN
  logic [2:0] cnt_out [NINST];
`endif

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [NINST-1:0] f;
    logic [2:0]       cnt;
  } exp_t;

  exp_t exp_q[$];

  string names [NINST] = '{"sop", "parity", "majority", "thresh2", "thresh0", "thresh5"};

  always #5 clk = ~clk;

`ifdef FUNC_COUNT_EN
  function_calling #(.MODE(0), .THRESH(2)) u_sop (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[0]), .ones_cnt(cnt_out[0]));
  function_calling #(.MODE(1), .THRESH(2)) u_par (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[1]), .ones_cnt(cnt_out[1]));
  function_calling #(.MODE(2), .THRESH(2)) u_maj (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[2]), .ones_cnt(cnt_out[2]));
  function_calling #(.MODE(3), .THRESH(2)) u_t2  (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[3]), .ones_cnt(cnt_out[3]));
  function_calling #(.MODE(3), .THRESH(0)) u_t0  (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[4]), .ones_cnt(cnt_out[4]));
  function_calling #(.MODE(3), .THRESH(5)) u_t5  (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[5]), .ones_cnt(cnt_out[5]));
`else
  function_calling #(.MODE(0), .THRESH(2)) u_sop (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[0]));
  function_calling #(.MODE(1), .THRESH(2)) u_par (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[1]));
  function_calling #(.MODE(2), .THRESH(2)) u_maj (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[2]));
  function_calling #(.MODE(3), .THRESH(2)) u_t2  (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[3]));
  function_calling #(.MODE(3), .THRESH(0)) u_t0  (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[4]));
  function_calling #(.MODE(3), .THRESH(5)) u_t5  (.clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f_out[5]));
`endif

  // Reference: count the ones, then apply each rule as plain arithmetic.
  function automatic exp_t model(input logic r, input logic [4:0] v);
    exp_t x;
    int n;
    int av, bv, cv, dv, ev;
    av = int'(v[4]); bv = int'(v[3]); cv = int'(v[2]); dv = int'(v[1]); ev = int'(v[0]);
    n = av + bv + cv + dv + ev;
    x.f[0] = (av * bv + cv * dv + ev) > 0;
    x.f[1] = (n % 2) == 1;
    x.f[2] = n >= 3;
    x.f[3] = n >= 2;
    x.f[4] = n >= 0;
    x.f[5] = n >= 5;
    x.cnt  = 3'(n);
    if (r) begin
      x.f   = '0;
      x.cnt = 3'd0;
    end
    return x;
  endfunction

  task automatic apply(input logic r, input logic [4:0] v);
    @(negedge clk);
    rst = r;
    {a, b, c, d, e} = v;
    exp_q.push_back(model(r, v));
  endtask

  // Monitor: one expected entry is consumed per rising edge once stimulus has started.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        for (int i = 0; i < NINST; i++) begin
          vectors++;
          if (f_out[i] !== x.f[i]) begin
            miscompares++;
            $display("FAIL %s f: got %b expected %b at %0t", names[i], f_out[i], x.f[i], $time);
          end
`ifdef FUNC_COUNT_EN
          vectors++;
          if (cnt_out[i] !== x.cnt) begin
            miscompares++;
            $display("FAIL %s ones_cnt: got %0d expected %0d at %0t", names[i], cnt_out[i], x.cnt, $time);
          end
`endif
        end
      end
    end
  end

  initial begin
    // Reset for two cycles, then the directed sequences.
    apply(1'b1, 5'b00000);
    apply(1'b1, 5'b00000);
    apply(1'b0, 5'b00000);
    apply(1'b0, 5'b00001);
    apply(1'b0, 5'b00010);
    apply(1'b0, 5'b00110);
    apply(1'b0, 5'b11000);
    apply(1'b1, 5'b11000);
    apply(1'b0, 5'b11000);
    apply(1'b0, 5'b00111);
    apply(1'b0, 5'b00011);
    apply(1'b0, 5'b11111);
    apply(1'b0, 5'b10101);
    apply(1'b0, 5'b00001);
    apply(1'b1, 5'b11111);
    // Full sweep of all operand values.
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 5'(i));
    end
    // Random operands with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 15) == 0), 5'($urandom));
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
